// File: rtl/corelet_seq_if.sv
// Handshake bundle between the WS instruction sequencer and its requester/corelet.
interface corelet_seq_if;
    logic        start;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    modport master (output start, output ofifo_valid, input inst, input busy, input done);
    modport slave  (input start, input ofifo_valid, output inst, output busy, output done);
endinterface

// File: rtl/corelet_seq.sv
// Weight-stationary instruction sequencer: walks every kij through weight fetch,
// kernel load, activation fetch, execute and OFIFO drain. Optional CORELET_SEQ_PERF_EN adds perf counters.
module corelet_seq #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_KIJ = 9,
    parameter int LEN_NIJ = 36,
    parameter int W_BASE  = 1024
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CORELET_SEQ_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [15:0] perf_stalls,
`endif
    corelet_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_FETCH, S_K_LOAD, S_A_FETCH, S_EXEC, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    localparam int K_END   = ROW + COL - 1;
    localparam int CNT_MAX = (COL > K_END) ? ((COL > LEN_NIJ) ? COL : LEN_NIJ)
                                           : ((K_END > LEN_NIJ) ? K_END : LEN_NIJ);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int PW = $clog2(LEN_NIJ + 1);
    localparam int KW = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1;

    localparam logic [CW-1:0] C_W_LAST = CW'(COL);
    localparam logic [CW-1:0] C_K_LAST = CW'(K_END);
    localparam logic [CW-1:0] C_A_LAST = CW'(LEN_NIJ);
    localparam logic [CW-1:0] C_E_LAST = CW'(LEN_NIJ - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(LEN_NIJ);
    localparam logic [KW-1:0] K_LAST   = KW'(LEN_KIJ - 1);

    // Both memories disabled (active-low CEN/WEN high), everything else off.
    localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nc;
    logic [KW-1:0] kij;
    logic [PW-1:0] p;

    function automatic logic [34:0] mk_inst(input logic ex, input logic kl, input logic l0w,
                                            input logic l0r, input logic ofr, input logic xcen,
                                            input logic [10:0] xa, input logic pcen,
                                            input logic [10:0] pa);
        logic [34:0] f;
        f        = INST_IDLE;
        f[0]     = kl;
        f[1]     = ex;
        f[2]     = l0w;
        f[3]     = l0r;
        f[6]     = ofr;
        f[17:7]  = xa;
        f[19]    = xcen;
        f[30:20] = pa;
        f[31]    = pcen;
        f[32]    = pcen;
        return f;
    endfunction

    function automatic logic [34:0] x_inst(input logic [10:0] xa, input logic xcen, input logic l0w);
        return mk_inst(1'b0, 1'b0, l0w, 1'b0, 1'b0, xcen, xa, 1'b1, 11'd0);
    endfunction

    function automatic logic [34:0] a_inst(input logic ex, input logic kl, input logic l0r);
        return mk_inst(ex, kl, 1'b0, l0r, 1'b0, 1'b1, 11'd0, 1'b1, 11'd0);
    endfunction

    function automatic logic [34:0] d_inst(input logic wr, input logic [10:0] pa);
        return wr ? mk_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, pa) : INST_IDLE;
    endfunction

    always_comb nc = cnt + CW'(1);

    // NOTE: the instruction for the next cycle is computed from the current state and
    // registered here with non-blocking assignments, so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kij      <= '0;
            p        <= '0;
            bus.inst <= INST_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    bus.inst <= INST_IDLE;
                    if (bus.start) begin
                        state    <= S_W_FETCH;
                        cnt      <= '0;
                        kij      <= '0;
                        bus.busy <= 1'b1;
                        bus.inst <= x_inst(11'(W_BASE), 1'b0, 1'b0);
                    end
                end
                S_W_FETCH: begin
                    if (cnt == C_W_LAST) begin
                        state    <= S_K_LOAD;
                        cnt      <= '0;
                        bus.inst <= a_inst(1'b0, 1'b1, 1'b1);
                    end else begin
                        cnt      <= nc;
                        bus.inst <= x_inst(11'(W_BASE + int'(kij) * COL + int'(nc)),
                                           nc == C_W_LAST, 1'b1);
                    end
                end
                S_K_LOAD: begin
                    if (cnt == C_K_LAST) begin
                        state    <= S_A_FETCH;
                        cnt      <= '0;
                        bus.inst <= x_inst(11'd0, 1'b0, 1'b0);
                    end else begin
                        cnt      <= nc;
                        bus.inst <= a_inst(1'b0, nc < C_W_LAST, nc < C_W_LAST);
                    end
                end
                S_A_FETCH: begin
                    if (cnt == C_A_LAST) begin
                        state    <= S_EXEC;
                        cnt      <= '0;
                        bus.inst <= a_inst(1'b1, 1'b0, 1'b1);
                    end else begin
                        cnt      <= nc;
                        bus.inst <= x_inst(11'(nc), nc == C_A_LAST, 1'b1);
                    end
                end
                S_EXEC: begin
                    if (cnt == C_E_LAST) begin
                        state    <= S_DRAIN;
                        cnt      <= '0;
                        p        <= PW'(bus.ofifo_valid);
                        bus.inst <= d_inst(bus.ofifo_valid, 11'(int'(kij) * LEN_NIJ));
                    end else begin
                        cnt      <= nc;
                        bus.inst <= a_inst(1'b1, 1'b0, 1'b1);
                    end
                end
                S_DRAIN: begin
                    if (p == P_LAST) begin
                        state    <= S_NEXT;
                        bus.inst <= INST_IDLE;
                    end else begin
                        // A stalled cycle issues no write and leaves p in place.
                        bus.inst <= d_inst(bus.ofifo_valid, 11'(int'(kij) * LEN_NIJ + int'(p)));
                        if (bus.ofifo_valid) p <= p + PW'(1);
                    end
                end
                S_NEXT: begin
                    if (kij == K_LAST) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.inst <= INST_IDLE;
                    end else begin
                        state    <= S_W_FETCH;
                        cnt      <= '0;
                        kij      <= kij + KW'(1);
                        bus.inst <= x_inst(11'(W_BASE + (int'(kij) + 1) * COL), 1'b0, 1'b0);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.inst <= INST_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.inst <= INST_IDLE;
                end
            endcase
        end
    end

`ifdef CORELET_SEQ_PERF_EN
    logic stall_next;

    always_comb begin
        stall_next = 1'b0;
        if (!bus.ofifo_valid && ((state == S_EXEC && cnt == C_E_LAST) ||
                                 (state == S_DRAIN && p != P_LAST)))
            stall_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && bus.start)) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (bus.busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (stall_next && perf_stalls != '1) perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// Self-checking bench for corelet_seq: a cycle-schedule model built from the
// phase lengths is compared against every instruction word under random OFIFO stalls.
module tb_corelet_seq;

    localparam int          MAXC = 2048;
    localparam logic [34:0] IDLE = 35'h1_800C_0000;

    logic clk = 1'b0;
    logic reset;
    logic drv_start, drv_valid, sel;

    always #5 clk = ~clk;

    corelet_seq_if bus_a ();
    corelet_seq_if bus_b ();

    assign bus_a.start       = drv_start & ~sel;
    assign bus_b.start       = drv_start & sel;
    assign bus_a.ofifo_valid = drv_valid;
    assign bus_b.ofifo_valid = drv_valid;

`ifdef CORELET_SEQ_PERF_EN
    logic [31:0] pc_a, pc_b;
    logic [15:0] ps_a, ps_b;
`endif

    corelet_seq dut_a (
        .clk         (clk),
        .reset       (reset),
`ifdef CORELET_SEQ_PERF_EN
        .perf_cycles (pc_a),
        .perf_stalls (ps_a),
`endif
        .bus         (bus_a.slave)
    );

    corelet_seq #(.LEN_KIJ(1), .LEN_NIJ(4)) dut_b (
        .clk         (clk),
        .reset       (reset),
`ifdef CORELET_SEQ_PERF_EN
        .perf_cycles (pc_b),
        .perf_stalls (ps_b),
`endif
        .bus         (bus_b.slave)
    );

    logic [34:0] s_inst;
    logic        s_busy, s_done;
    assign s_inst = sel ? bus_b.inst : bus_a.inst;
    assign s_busy = sel ? bus_b.busy : bus_a.busy;
    assign s_done = sel ? bus_b.done : bus_a.done;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [34:0] e_inst [MAXC];
    logic        e_busy [MAXC];
    logic        e_done [MAXC];
    bit          vpat   [MAXC];
    int          exp_done, exp_stalls;

    int obs_writes, obs_last_pa, obs_done_at, obs_pulses, obs_xa0, obs_xa135;

    // Expected per-cycle words, cycle 0 being the first cycle after the accepted start.
    task automatic build_model(input int lk, input int ln, input int r, input int c, input int wb);
        int t, w, ws, kl, af, ex;
        for (int i = 0; i < MAXC; i++) begin
            e_inst[i] = IDLE;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
        end
        t = 0;
        exp_stalls = 0;
        for (int k = 0; k < lk; k++) begin
            ws = t;
            for (int j = 0; j < c; j++) begin
                e_inst[ws + j][19]   = 1'b0;
                e_inst[ws + j][17:7] = 11'(wb + k * c + j);
                e_inst[ws + j + 1][2] = 1'b1;
            end
            kl = ws + c + 1;
            for (int j = 0; j < c; j++) begin
                e_inst[kl + j][0] = 1'b1;
                e_inst[kl + j][3] = 1'b1;
            end
            af = kl + r + c;
            for (int j = 0; j < ln; j++) begin
                e_inst[af + j][19]   = 1'b0;
                e_inst[af + j][17:7] = 11'(j);
                e_inst[af + j + 1][2] = 1'b1;
            end
            ex = af + ln + 1;
            for (int j = 0; j < ln; j++) begin
                e_inst[ex + j][1] = 1'b1;
                e_inst[ex + j][3] = 1'b1;
            end
            t = ex + ln;
            w = 0;
            while (w < ln && t < MAXC - 8) begin
                if (vpat[t]) begin
                    e_inst[t][6]     = 1'b1;
                    e_inst[t][31]    = 1'b0;
                    e_inst[t][32]    = 1'b0;
                    e_inst[t][30:20] = 11'(k * ln + w);
                    w++;
                end else begin
                    exp_stalls++;
                end
                t++;
            end
            t++;
        end
        exp_done = t;
        for (int i = 0; i < t; i++) e_busy[i] = 1'b1;
        e_done[t] = 1'b1;
    endtask

    function automatic logic [34:0] care(input logic [34:0] v);
        logic [34:0] m;
        m = '1;
        if (v[19]) m[17:7]  = '0;
        if (v[32]) m[30:20] = '0;
        return m;
    endfunction

    task automatic run(input bit which, input int lk, input int ln, input int rst_at,
                       input int extra_start, input string name);
        int          horizon;
        logic [34:0] ev;
        logic        eb, ed;
        sel = which;
        build_model(lk, ln, 8, 8, 1024);
        horizon = (rst_at >= 0) ? rst_at + 4 : exp_done + 3;
        obs_writes = 0; obs_last_pa = -1; obs_done_at = -1; obs_pulses = 0;
        obs_xa0 = -1; obs_xa135 = -1;
        @(negedge clk);
        for (int t = 0; t <= horizon; t++) begin
            drv_start = (t == 0) || (t == extra_start) || (rst_at < 0 && t == exp_done + 1);
            drv_valid = vpat[t];
            reset     = (t == rst_at);
            @(posedge clk);
            @(negedge clk);
            if (rst_at >= 0 && t >= rst_at) begin
                ev = IDLE; eb = 1'b0; ed = 1'b0;
            end else begin
                ev = e_inst[t]; eb = e_busy[t]; ed = e_done[t];
            end
            check($sformatf("%s_cyc%0d", name, t), {s_busy, s_done, s_inst & care(ev)},
                  {eb, ed, ev & care(ev)});
            if (!s_inst[32]) begin
                obs_writes++;
                obs_last_pa = int'(s_inst[30:20]);
            end
            if (s_done) begin
                obs_pulses++;
                obs_done_at = t;
            end
            if (t == 0)   obs_xa0   = int'(s_inst[17:7]);
            if (t == 135) obs_xa135 = int'(s_inst[17:7]);
        end
        drv_start = 1'b0;
        drv_valid = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; drv_start = 1'b0; drv_valid = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_a", {bus_a.busy, bus_a.done, bus_a.inst}, {2'b00, IDLE});
        end
        check("idle_b", {bus_b.busy, bus_b.done, bus_b.inst}, {2'b00, IDLE});

        // Defaults, no stalls, start pulsed during EXEC of kij 0 and during DONE.
        for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
        run(1'b0, 9, 36, -1, 70, "dflt");
        check("dflt_writes", obs_writes, 324);
        check("dflt_last_pa", obs_last_pa, 323);
        check("dflt_done_at", obs_done_at, 1215);
        check("dflt_pulses", obs_pulses, 1);
        check("dflt_xa0", obs_xa0, 1024);
        check("dflt_xa_kij1", obs_xa135, 1032);
`ifdef CORELET_SEQ_PERF_EN
        check("dflt_perf_cycles", pc_a, 1215);
        check("dflt_perf_stalls", ps_a, 0);
`endif

        // Five-cycle OFIFO stall in the middle of the kij 0 drain.
        for (int i = 110; i < 115; i++) vpat[i] = 1'b0;
        run(1'b0, 9, 36, -1, -1, "stall");
        check("stall_writes", obs_writes, 324);
        check("stall_last_pa", obs_last_pa, 323);
        check("stall_done_at", obs_done_at, 1220);
`ifdef CORELET_SEQ_PERF_EN
        check("stall_perf_cycles", pc_a, 1220);
        check("stall_perf_stalls", ps_a, 5);
`endif

        // Reset during K_LOAD of kij 3.
        for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
        run(1'b0, 9, 36, 420, -1, "rst");
        check("rst_writes", obs_writes, 108);
`ifdef CORELET_SEQ_PERF_EN
        check("rst_perf_cycles", pc_a, 0);
`endif

        // Random OFIFO availability after the reset-aborted run.
        for (int i = 0; i < MAXC; i++) vpat[i] = ($urandom_range(0, 3) != 0);
        run(1'b0, 9, 36, -1, -1, "rand");
        check("rand_writes", obs_writes, 324);
        check("rand_last_pa", obs_last_pa, 323);
        check("rand_xa0", obs_xa0, 1024);
        check("rand_done_at", obs_done_at, exp_done);
`ifdef CORELET_SEQ_PERF_EN
        check("rand_perf_stalls", ps_a, exp_stalls);
`endif

        // Small configuration: one kernel position, four activation vectors.
        for (int i = 0; i < MAXC; i++) vpat[i] = ($urandom_range(0, 2) != 0);
        run(1'b1, 1, 4, -1, -1, "small");
        check("small_writes", obs_writes, 4);
        check("small_last_pa", obs_last_pa, 3);
        check("small_pulses", obs_pulses, 1);
        check("small_done_at", obs_done_at, exp_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
